// File: rtl/cpu_insn_fifo_pkg.sv
// Shared constants for the moxie instruction FIFO.
// Holds the default depth and the table of long (48-bit) major opcodes.
package cpu_insn_fifo_pkg;

  localparam int DEPTH_DEF = 16;
  localparam int N_LONG = 18;

  localparam logic [7:0] LONG_OPS [N_LONG] = '{
    8'h01, 8'h03, 8'h08, 8'h09, 8'h0C, 8'h0D,
    8'h1A, 8'h1B, 8'h1D, 8'h1F, 8'h20, 8'h22,
    8'h24, 8'h30, 8'h36, 8'h37, 8'h38, 8'h39
  };

endpackage

// File: rtl/cpu_insn_fifo_if.sv
// Fetch/decode side signals of the instruction FIFO.
// master drives requests and data, slave is the FIFO itself.
interface cpu_insn_fifo_if;

  logic        stall_i;
  logic [31:0] PC_i;
  logic        newPC_p_i;
  logic        write_en_i;
  logic [31:0] data_i;
  logic        read_en_i;
  logic [15:0] opcode_o;
  logic [31:0] operand_o;
  logic        valid_o;
  logic        empty_o;
  logic        full_o;
  logic [31:0] PC_o;

  modport master (
    output stall_i, PC_i, newPC_p_i,
    output write_en_i, data_i, read_en_i,
    input  opcode_o, operand_o, valid_o,
    input  empty_o, full_o, PC_o
  );

  modport slave (
    input  stall_i, PC_i, newPC_p_i,
    input  write_en_i, data_i, read_en_i,
    output opcode_o, operand_o, valid_o,
    output empty_o, full_o, PC_o
  );

endinterface

// File: rtl/cpu_insn_fifo_len.sv
// Length decode of a moxie head halfword.
// Long forms carry a 32-bit operand in the next two halfwords.
module cpu_insn_len
  import cpu_insn_fifo_pkg::*;
(
  input  logic [15:0] h,
  output logic        is_long
);

  // Form-1 opcodes only; any h[15]=1 encoding is short
  always_comb begin
    is_long = 1'b0;
    if (!h[15]) begin
      for (int i = 0; i < N_LONG; i++) begin
        if (h[15:8] == LONG_OPS[i]) is_long = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_insn_fifo.sv
// Halfword instruction FIFO between fetch and decode.
// Pushes 32-bit fetch words, pops whole 16/48-bit instructions.
module cpu_insn_fifo
  import cpu_insn_fifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input logic clk_i,
  input logic rst_i,
  cpu_insn_fifo_if.slave bus
);

  localparam int CNT_W = PTR_W + 1;

  logic [15:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [31:0]      ip;

  logic [PTR_W-1:0] wr_p1;
  logic [PTR_W-1:0] rd_p1;
  logic [PTR_W-1:0] rd_p2;
  logic [15:0]      head;
  logic             is_long;
  logic             push;
  logic             rd_go;
  logic             ok_short;
  logic             ok_long;
  logic             pop;
  logic [CNT_W-1:0] pop_n;
  logic [CNT_W-1:0] push_n;

  assign wr_p1 = wr_ptr + PTR_W'(1);
  assign rd_p1 = rd_ptr + PTR_W'(1);
  assign rd_p2 = rd_ptr + PTR_W'(2);
  assign head  = mem[rd_ptr];

  cpu_insn_len u_len (
    .h       (head),
    .is_long (is_long)
  );

  assign bus.empty_o = (count == '0);
  assign bus.full_o  = (count > CNT_W'(DEPTH - 2));

  assign push     = bus.write_en_i && !bus.full_o;
  assign rd_go    = bus.read_en_i && !bus.stall_i;
  assign ok_short = !is_long && (count >= CNT_W'(1));
  assign ok_long  = is_long && (count >= CNT_W'(3));
  assign pop      = rd_go && (ok_short || ok_long);
  assign pop_n    = !pop ? '0 :
                    (is_long ? CNT_W'(3) : CNT_W'(1));
  assign push_n   = push ? CNT_W'(2) : '0;

  // Halfword storage, earlier halfword of a word first
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= bus.data_i[31:16];
      mem[wr_p1]  <= bus.data_i[15:0];
    end
  end

  // Pointers, occupancy and instruction pointer
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ip     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(2);
      rd_ptr <= rd_ptr + pop_n[PTR_W-1:0];
      count  <= count + push_n - pop_n;
      if (bus.newPC_p_i)
        ip <= bus.PC_i;
      else if (pop)
        ip <= ip + (is_long ? 32'd6 : 32'd2);
    end
  end

  // Presented instruction; a stall freezes everything
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bus.opcode_o  <= '0;
      bus.operand_o <= '0;
      bus.PC_o      <= '0;
      bus.valid_o   <= 1'b0;
    end else if (!bus.stall_i) begin
      bus.valid_o <= pop;
      if (pop) begin
        bus.opcode_o  <= head;
        bus.operand_o <= is_long ?
                         {mem[rd_p1], mem[rd_p2]} : 32'd0;
        bus.PC_o      <= ip;
      end
    end
  end

endmodule

// File: tb/tb_cpu_insn_fifo.sv
// Directed self-checking bench for cpu_insn_fifo.
// Expected values are hand-derived from the moxie length rules.
module tb_cpu_insn_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  cpu_insn_fifo_if bus ();

  cpu_insn_fifo dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.stall_i    = 1'b0;
    bus.PC_i       = '0;
    bus.newPC_p_i  = 1'b0;
    bus.write_en_i = 1'b0;
    bus.data_i     = '0;
    bus.read_en_i  = 1'b0;

    // reset state
    tick();
    tick();
    chk("rst_empty", 64'(bus.empty_o), 64'd1);
    chk("rst_full", 64'(bus.full_o), 64'd0);
    chk("rst_valid", 64'(bus.valid_o), 64'd0);
    chk("rst_pc", 64'(bus.PC_o), 64'd0);
    chk("rst_opc", 64'(bus.opcode_o), 64'd0);
    rst_n = 1'b1;
    tick();

    // long then short
    bus.newPC_p_i  = 1'b1;
    bus.PC_i       = 32'h1000;
    bus.write_en_i = 1'b1;
    bus.data_i     = 32'h0100DEAD;
    tick();
    bus.newPC_p_i  = 1'b0;
    bus.data_i     = 32'hBEEF0500;
    tick();
    bus.write_en_i = 1'b0;
    bus.read_en_i  = 1'b1;
    tick();
    chk("ls1_valid", 64'(bus.valid_o), 64'd1);
    chk("ls1_opc", 64'(bus.opcode_o), 64'h0100);
    chk("ls1_opd", 64'(bus.operand_o), 64'hDEADBEEF);
    chk("ls1_pc", 64'(bus.PC_o), 64'h1000);
    tick();
    chk("ls2_valid", 64'(bus.valid_o), 64'd1);
    chk("ls2_opc", 64'(bus.opcode_o), 64'h0500);
    chk("ls2_opd", 64'(bus.operand_o), 64'h0);
    chk("ls2_pc", 64'(bus.PC_o), 64'h1006);
    bus.read_en_i = 1'b0;
    tick();
    chk("ls_idle_valid", 64'(bus.valid_o), 64'd0);
    chk("ls_empty", 64'(bus.empty_o), 64'd1);

    // partial long instruction waits for its operand
    bus.write_en_i = 1'b1;
    bus.data_i     = 32'h0C12AAAA;
    tick();
    bus.write_en_i = 1'b0;
    bus.read_en_i  = 1'b1;
    tick();
    chk("pl_valid", 64'(bus.valid_o), 64'd0);
    chk("pl_count", 64'(dut.count), 64'd2);
    chk("pl_hold", 64'(bus.opcode_o), 64'h0500);
    bus.read_en_i  = 1'b0;
    bus.write_en_i = 1'b1;
    bus.data_i     = 32'hBBBB0000;
    tick();
    bus.write_en_i = 1'b0;
    bus.read_en_i  = 1'b1;
    tick();
    chk("pl_valid2", 64'(bus.valid_o), 64'd1);
    chk("pl_opc", 64'(bus.opcode_o), 64'h0C12);
    chk("pl_opd", 64'(bus.operand_o), 64'hAAAABBBB);
    chk("pl_pc", 64'(bus.PC_o), 64'h1008);
    tick();
    chk("pl_tail_opc", 64'(bus.opcode_o), 64'h0000);
    chk("pl_tail_pc", 64'(bus.PC_o), 64'h100E);
    chk("pl_empty", 64'(bus.empty_o), 64'd1);
    bus.read_en_i = 1'b0;
    tick();

    // fill to full, drop the extra word, drain in order
    bus.write_en_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.data_i = {16'(16'h8000 + 2 * i),
                    16'(16'h8001 + 2 * i)};
      tick();
      if (i == 6) chk("full_at14", 64'(bus.full_o), 64'd0);
    end
    chk("full_set", 64'(bus.full_o), 64'd1);
    bus.data_i = 32'hFFFFFFFF;
    tick();
    chk("full_drop_cnt", 64'(dut.count), 64'd16);
    bus.write_en_i = 1'b0;
    bus.read_en_i  = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk($sformatf("drain_opc%0d", k),
          64'(bus.opcode_o), 64'(16'h8000 + k));
      chk($sformatf("drain_pc%0d", k),
          64'(bus.PC_o), 64'(32'h1010 + 2 * k));
    end
    chk("drain_empty", 64'(bus.empty_o), 64'd1);
    bus.read_en_i = 1'b0;
    tick();

    // stall freezes outputs and occupancy
    bus.write_en_i = 1'b1;
    bus.data_i     = 32'h81008200;
    tick();
    bus.write_en_i = 1'b0;
    bus.read_en_i  = 1'b1;
    tick();
    chk("st_opc0", 64'(bus.opcode_o), 64'h8100);
    chk("st_pc0", 64'(bus.PC_o), 64'h1030);
    bus.stall_i = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("st_valid", 64'(bus.valid_o), 64'd1);
      chk("st_opc", 64'(bus.opcode_o), 64'h8100);
      chk("st_cnt", 64'(dut.count), 64'd1);
    end
    bus.stall_i = 1'b0;
    tick();
    chk("st_rel_valid", 64'(bus.valid_o), 64'd1);
    chk("st_rel_opc", 64'(bus.opcode_o), 64'h8200);
    chk("st_rel_pc", 64'(bus.PC_o), 64'h1032);
    bus.read_en_i = 1'b0;

    // redirect wins over the increment of a same-cycle pop
    bus.write_en_i = 1'b1;
    bus.data_i     = 32'h83008400;
    tick();
    bus.write_en_i = 1'b0;
    bus.read_en_i  = 1'b1;
    bus.newPC_p_i  = 1'b1;
    bus.PC_i       = 32'h2000;
    tick();
    chk("rd_opc0", 64'(bus.opcode_o), 64'h8300);
    chk("rd_pc0", 64'(bus.PC_o), 64'h1034);
    bus.newPC_p_i  = 1'b0;
    bus.write_en_i = 1'b1;
    bus.data_i     = 32'h85008600;
    tick();
    chk("rd_opc1", 64'(bus.opcode_o), 64'h8400);
    chk("rd_pc1", 64'(bus.PC_o), 64'h2000);
    chk("rd_cnt", 64'(dut.count), 64'd2);
    chk("pre_rst_empty", 64'(bus.empty_o), 64'd0);
    bus.write_en_i = 1'b0;
    bus.read_en_i  = 1'b0;

    // asynchronous reset mid-stream, between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_empty", 64'(bus.empty_o), 64'd1);
    chk("arst_full", 64'(bus.full_o), 64'd0);
    chk("arst_valid", 64'(bus.valid_o), 64'd0);
    chk("arst_pc", 64'(bus.PC_o), 64'd0);
    chk("arst_cnt", 64'(dut.count), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
